// File: rtl/mega_alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : mega_alu_issue_wb
// Description : Issue/writeback wrapper around mega_alu. Decodes the AVR opcode,
//               reads the 32x8 register file and SREG into the ISSUE stage, and
//               commits the ALU result one edge later. Optional macro
//               MEGA_ALU_ISSUE_FWD_EN enables register bypass (no stalls).
// Revision    : 1.0 - initial release
// ============================================================================
module mega_alu_issue_wb #(
    parameter int CORE_TYPE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    output logic        inst_ready,
    output logic [15:0] alu_inst,
    output logic [4:0]  alu_rda,
    output logic [15:0] alu_rd,
    output logic [4:0]  alu_rra,
    output logic [15:0] alu_rr,
    output logic [7:0]  alu_sreg,
    output logic        alu_valid,
    input  logic [15:0] alu_r,
    input  logic [7:0]  alu_sreg_out,
    input  logic [4:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [1:0] c_WR_NONE = 2'd0;
    localparam logic [1:0] c_WR_BYTE = 2'd1;
    localparam logic [1:0] c_WR_WORD = 2'd2;
    localparam logic [1:0] c_WR_MUL  = 2'd3;
    localparam int         c_CORE_CLASSIC = 0;

    // Classic cores lack MOVW and the multiplier family.
    logic w_enh;
    assign w_enh = (CORE_TYPE != c_CORE_CLASSIC);

    logic [7:0]  rf_q [32];
    logic [7:0]  rf_d [32];
    logic [7:0]  w_rf_view [32];
    logic [7:0]  sreg_q, sreg_d;
    logic [15:0] alu_inst_q, alu_inst_d;
    logic [4:0]  alu_rda_q, alu_rda_d, alu_rra_q, alu_rra_d;
    logic [15:0] alu_rd_q, alu_rd_d, alu_rr_q, alu_rr_d;
    logic [7:0]  alu_sreg_q, alu_sreg_d;
    logic        alu_valid_q, alu_valid_d;
    logic [1:0]  cls_q, cls_d;
    logic        in_set_q, in_set_d;

    logic [4:0]  w_rda, w_rra;
    logic [1:0]  w_cls;
    logic        w_in_set, w_use_rd, w_use_rr, w_word_rd, w_word_rr;
    logic [31:0] w_wr_mask;
    logic [4:0]  w_wr_lo, w_wr_hi;
    logic        w_accept;

    always_comb begin
        w_rda     = 5'd0;
        w_rra     = 5'd0;
        w_cls     = c_WR_NONE;
        w_in_set  = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rr  = 1'b0;
        w_word_rd = 1'b0;
        w_word_rr = 1'b0;
        casez (inst)
            16'b0000_0001_????_????: if (w_enh) begin
                w_in_set = 1'b1; w_cls = c_WR_WORD;
                w_rda = {inst[7:4], 1'b0}; w_rra = {inst[3:0], 1'b0};
                w_use_rr = 1'b1; w_word_rr = 1'b1;
            end
            16'b0000_0010_????_????: if (w_enh) begin
                w_in_set = 1'b1; w_cls = c_WR_MUL;
                w_rda = {1'b1, inst[7:4]}; w_rra = {1'b1, inst[3:0]};
                w_use_rd = 1'b1; w_use_rr = 1'b1;
            end
            16'b0000_0011_????_????: if (w_enh) begin
                w_in_set = 1'b1; w_cls = c_WR_MUL;
                w_rda = {2'b10, inst[6:4]}; w_rra = {2'b10, inst[2:0]};
                w_use_rd = 1'b1; w_use_rr = 1'b1;
            end
            16'b0000_01??_????_????, 16'b0001_01??_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_NONE;
                w_rda = inst[8:4]; w_rra = {inst[9], inst[3:0]};
                w_use_rd = 1'b1; w_use_rr = 1'b1;
            end
            16'b0000_1???_????_????, 16'b0001_1???_????_????, 16'b0010_????_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_BYTE;
                w_rda = inst[8:4]; w_rra = {inst[9], inst[3:0]};
                w_use_rd = 1'b1; w_use_rr = 1'b1;
            end
            16'b1001_11??_????_????: if (w_enh) begin
                w_in_set = 1'b1; w_cls = c_WR_MUL;
                w_rda = inst[8:4]; w_rra = {inst[9], inst[3:0]};
                w_use_rd = 1'b1; w_use_rr = 1'b1;
            end
            16'b0011_????_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_NONE;
                w_rda = {1'b1, inst[7:4]}; w_use_rd = 1'b1;
            end
            16'b01??_????_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_BYTE;
                w_rda = {1'b1, inst[7:4]}; w_use_rd = 1'b1;
            end
            16'b1110_????_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_BYTE;
                w_rda = {1'b1, inst[7:4]};
            end
            16'b1001_011?_????_????: begin
                w_in_set = 1'b1; w_cls = c_WR_WORD;
                w_rda = {2'b11, inst[5:4], 1'b0};
                w_use_rd = 1'b1; w_word_rd = 1'b1;
            end
            16'b1001_010?_????_????: begin
                if (inst[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'hA}) begin
                    w_in_set = 1'b1; w_cls = c_WR_BYTE;
                    w_rda = inst[8:4]; w_use_rd = 1'b1;
                end else if (!inst[8] && inst[3:0] == 4'h8) begin
                    w_in_set = 1'b1; w_cls = c_WR_NONE;
                end
            end
            16'b1111_10??_????_0???: begin
                w_in_set = 1'b1; w_cls = inst[9] ? c_WR_NONE : c_WR_BYTE;
                w_rda = inst[8:4]; w_use_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Bytes the instruction currently in ISSUE commits at the coming edge.
    always_comb begin
        w_wr_mask = 32'd0;
        w_wr_lo   = alu_rda_q;
        w_wr_hi   = alu_rda_q + 5'd1;
        if (cls_q == c_WR_MUL) begin
            w_wr_lo = 5'd0;
            w_wr_hi = 5'd1;
        end
        if (alu_valid_q) begin
            if (cls_q != c_WR_NONE) w_wr_mask[w_wr_lo] = 1'b1;
            if (cls_q == c_WR_WORD || cls_q == c_WR_MUL) w_wr_mask[w_wr_hi] = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
            if (w_wr_mask[i]) rf_d[i] = (5'(i) == w_wr_lo) ? alu_r[7:0] : alu_r[15:8];
        end
    end

`ifdef MEGA_ALU_ISSUE_FWD_EN
    assign inst_ready = 1'b1;
    always_comb begin
        for (int i = 0; i < 32; i++) w_rf_view[i] = rf_d[i];
    end
`else
    logic [31:0] w_rd_mask;
    always_comb begin
        w_rd_mask = 32'd0;
        if (w_use_rd) begin
            w_rd_mask[w_rda] = 1'b1;
            if (w_word_rd) w_rd_mask[w_rda + 5'd1] = 1'b1;
        end
        if (w_use_rr) begin
            w_rd_mask[w_rra] = 1'b1;
            if (w_word_rr) w_rd_mask[w_rra + 5'd1] = 1'b1;
        end
        for (int i = 0; i < 32; i++) w_rf_view[i] = rf_q[i];
    end
    // One-cycle stall: the next cycle ISSUE is empty, so the hazard clears.
    assign inst_ready = ~|(w_wr_mask & w_rd_mask);
`endif

    assign w_accept = inst_valid & inst_ready;

    always_comb begin
        sreg_d      = (alu_valid_q && in_set_q) ? alu_sreg_out : sreg_q;
        alu_valid_d = w_accept;
        alu_inst_d  = alu_inst_q;
        alu_rda_d   = alu_rda_q;
        alu_rra_d   = alu_rra_q;
        alu_rd_d    = alu_rd_q;
        alu_rr_d    = alu_rr_q;
        alu_sreg_d  = alu_sreg_q;
        cls_d       = cls_q;
        in_set_d    = in_set_q;
        if (w_accept) begin
            alu_inst_d = inst;
            alu_rda_d  = w_rda;
            alu_rra_d  = w_rra;
            alu_rd_d   = {(w_rda == 5'd31) ? 8'h00 : w_rf_view[w_rda + 5'd1], w_rf_view[w_rda]};
            alu_rr_d   = {(w_rra == 5'd31) ? 8'h00 : w_rf_view[w_rra + 5'd1], w_rf_view[w_rra]};
            alu_sreg_d = sreg_d;
            cls_d      = w_cls;
            in_set_d   = w_in_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 8'h00;
            sreg_q      <= 8'h00;
            alu_valid_q <= 1'b0;
            alu_inst_q  <= 16'h0000;
            alu_rda_q   <= 5'd0;
            alu_rra_q   <= 5'd0;
            alu_rd_q    <= 16'h0000;
            alu_rr_q    <= 16'h0000;
            alu_sreg_q  <= 8'h00;
            cls_q       <= c_WR_NONE;
            in_set_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
            sreg_q      <= sreg_d;
            alu_valid_q <= alu_valid_d;
            alu_inst_q  <= alu_inst_d;
            alu_rda_q   <= alu_rda_d;
            alu_rra_q   <= alu_rra_d;
            alu_rd_q    <= alu_rd_d;
            alu_rr_q    <= alu_rr_d;
            alu_sreg_q  <= alu_sreg_d;
            cls_q       <= cls_d;
            in_set_q    <= in_set_d;
        end
    end

    assign alu_inst  = alu_inst_q;
    assign alu_rda   = alu_rda_q;
    assign alu_rra   = alu_rra_q;
    assign alu_rd    = alu_rd_q;
    assign alu_rr    = alu_rr_q;
    assign alu_sreg  = alu_sreg_q;
    assign alu_valid = alu_valid_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_mega_alu_issue_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mega_alu_issue_wb
// Description : Directed bench for mega_alu_issue_wb with a small ALU model
//               (LDI, MOV, ADD, CP, MUL, ADIW) closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mega_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic        inst_ready;
    logic [15:0] alu_inst, alu_rd, alu_rr, alu_r;
    logic [4:0]  alu_rda, alu_rra;
    logic [7:0]  alu_sreg, alu_sreg_out;
    logic        alu_valid;
    logic [4:0]  dbg_addr = 5'd0;
    logic [7:0]  dbg_data;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int st;

`ifdef MEGA_ALU_ISSUE_FWD_EN
    localparam logic [15:0] c_STALL = 16'd0;
`else
    localparam logic [15:0] c_STALL = 16'd1;
`endif

    always #5 clk = ~clk;

    mega_alu_issue_wb #(.CORE_TYPE(1)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .alu_inst(alu_inst), .alu_rda(alu_rda), .alu_rd(alu_rd), .alu_rra(alu_rra),
        .alu_rr(alu_rr), .alu_sreg(alu_sreg), .alu_valid(alu_valid), .alu_r(alu_r),
        .alu_sreg_out(alu_sreg_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU; SREG bits are I T H S V N Z C from 7 down to 0.
    logic [8:0] m_sum;
    logic [4:0] m_h;
    logic [7:0] m_d;
    always_comb begin
        alu_r = 16'h0000;
        alu_sreg_out = alu_sreg;
        m_sum = 9'd0;
        m_h = 5'd0;
        m_d = 8'd0;
        casez (alu_inst)
            16'b1110_????_????_????: alu_r = {8'h00, alu_inst[11:8], alu_inst[3:0]};
            16'b0010_11??_????_????: alu_r = {8'h00, alu_rr[7:0]};
            16'b0000_11??_????_????: begin
                m_sum = {1'b0, alu_rd[7:0]} + {1'b0, alu_rr[7:0]};
                m_h = {1'b0, alu_rd[3:0]} + {1'b0, alu_rr[3:0]};
                alu_r = {8'h00, m_sum[7:0]};
                alu_sreg_out[0] = m_sum[8];
                alu_sreg_out[1] = (m_sum[7:0] == 8'h00);
                alu_sreg_out[2] = m_sum[7];
                alu_sreg_out[3] = (alu_rd[7] == alu_rr[7]) && (m_sum[7] != alu_rd[7]);
                alu_sreg_out[4] = alu_sreg_out[2] ^ alu_sreg_out[3];
                alu_sreg_out[5] = m_h[4];
            end
            16'b0001_01??_????_????: begin
                m_d = alu_rd[7:0] - alu_rr[7:0];
                alu_sreg_out[0] = alu_rd[7:0] < alu_rr[7:0];
                alu_sreg_out[1] = (m_d == 8'h00);
                alu_sreg_out[2] = m_d[7];
                alu_sreg_out[3] = (alu_rd[7] != alu_rr[7]) && (m_d[7] != alu_rd[7]);
                alu_sreg_out[4] = alu_sreg_out[2] ^ alu_sreg_out[3];
                alu_sreg_out[5] = alu_rd[3:0] < alu_rr[3:0];
            end
            16'b1001_11??_????_????: begin
                alu_r = 16'(alu_rd[7:0]) * 16'(alu_rr[7:0]);
                alu_sreg_out[0] = alu_r[15];
                alu_sreg_out[1] = (alu_r == 16'h0000);
            end
            16'b1001_0110_????_????: begin
                alu_r = alu_rd + {10'd0, alu_inst[7:6], alu_inst[3:0]};
                alu_sreg_out[3] = !alu_rd[15] && alu_r[15];
                alu_sreg_out[2] = alu_r[15];
                alu_sreg_out[4] = alu_sreg_out[2] ^ alu_sreg_out[3];
                alu_sreg_out[1] = (alu_r == 16'h0000);
                alu_sreg_out[0] = !alu_r[15] && alu_rd[15];
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    // Presents op at a negedge, waits (bounded) for inst_ready, returns at the
    // negedge after acceptance with the instruction sitting in ISSUE.
    task automatic issue(input logic [15:0] op, output int stalls);
        stalls = 0;
        inst = op;
        inst_valid = 1'b1;
        #1;
        while (!inst_ready && stalls < 4) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!inst_ready) begin
            n_total++;
            n_fail++;
            $error("FAIL issue_timeout: op 0x%04h never accepted", op);
        end
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", {15'd0, alu_valid}, 16'd0);
        chk("rst_inst", alu_inst, 16'h0000);
        chk("rst_rda_rra", {3'd0, alu_rda, 3'd0, alu_rra}, 16'h0000);
        chk("rst_rd", alu_rd, 16'h0000);
        chk("rst_rr", alu_rr, 16'h0000);
        chk("rst_sreg", {8'h00, alu_sreg}, 16'h0000);
        chk_dbg("rst_r16", 5'd16, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_ready", {15'd0, inst_ready}, 16'd1);

        // LDI R16,0x5A ; LDI R17,0x5A ; ADD R16,R17
        issue(16'hE50A, st);
        chk("ldi_no_stall", 16'(st), 16'd0);
        issue(16'hE51A, st);
        issue(16'h0F01, st);
        chk("add_stall", 16'(st), c_STALL);
        chk("add_valid", {15'd0, alu_valid}, 16'd1);
        chk("add_inst", alu_inst, 16'h0F01);
        chk("add_rda_rra", {3'd0, alu_rda, 3'd0, alu_rra}, {8'd16, 8'd17});
        chk("add_rd", alu_rd, 16'h5A5A);
        chk("add_rr", alu_rr, 16'h005A);
        issue(16'h0000, st);
        chk("add_sreg", {8'h00, alu_sreg}, 16'h002C);
        chk_dbg("add_r16", 5'd16, 8'hB4);
        chk_dbg("add_r17", 5'd17, 8'h5A);

        // MUL R16,R17 with both 0x5A, then MOV R2,R1 reads the fresh high byte
        issue(16'hE50A, st);
        issue(16'h9F01, st);
        chk("mul_stall", 16'(st), c_STALL);
        chk("mul_rd", alu_rd, 16'h5A5A);
        issue(16'h2C21, st);
        chk("mov_stall", 16'(st), c_STALL);
        chk("mov_rr_r1", alu_rr, 16'h001F);
        chk("mul_sreg", {8'h00, alu_sreg}, 16'h002C);
        issue(16'h0000, st);
        chk_dbg("mul_r0", 5'd0, 8'hA4);
        chk_dbg("mul_r1", 5'd1, 8'h1F);
        chk_dbg("mov_r2", 5'd2, 8'h1F);

        // LDI R24,0xFF ; LDI R25,0xFF ; ADIW R24,1
        issue(16'hEF8F, st);
        issue(16'hEF9F, st);
        issue(16'h9601, st);
        chk("adiw_stall", 16'(st), c_STALL);
        chk("adiw_rda", {11'd0, alu_rda}, 16'd24);
        chk("adiw_rd", alu_rd, 16'hFFFF);
        issue(16'h0000, st);
        chk("adiw_sreg", {8'h00, alu_sreg}, 16'h0023);
        chk_dbg("adiw_r24", 5'd24, 8'h00);
        chk_dbg("adiw_r25", 5'd25, 8'h00);

        // R16=R17=0x33 ; CP R16,R17
        issue(16'hE303, st);
        issue(16'hE313, st);
        issue(16'h1701, st);
        chk("cp_stall", 16'(st), c_STALL);
        chk("cp_rd_rr", {alu_rd[7:0], alu_rr[7:0]}, 16'h3333);
        issue(16'h0000, st);
        chk("cp_sreg", {8'h00, alu_sreg}, 16'h0002);
        chk_dbg("cp_r16", 5'd16, 8'h33);
        chk_dbg("cp_r17", 5'd17, 8'h33);

        // ADD pending in ISSUE when reset arrives on its commit edge
        issue(16'h0F01, st);
        chk("rstwb_issued", {15'd0, alu_valid}, 16'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstwb_valid", {15'd0, alu_valid}, 16'd0);
        chk("rstwb_inst", alu_inst, 16'h0000);
        chk("rstwb_rd_rr", alu_rd | alu_rr, 16'h0000);
        chk("rstwb_sreg", {8'h00, alu_sreg}, 16'h0000);
        chk_dbg("rstwb_r16", 5'd16, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
